// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner: the scanner state
// enum, the column count and the Pmod KYPD key map with its lookup helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam int NUM_COLS = 4;
  localparam int COL_W    = $clog2(NUM_COLS);

  // Sixteen 4-bit codes indexed by {row, col}; entry 0 (row 0, col 0) sits
  // in the least significant nibble.
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,   // row 3
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                            input logic [1:0] col);
    logic [3:0] idx;
    idx = {row, col};
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous inputs.
// Resets to all ones so that idle pulled-up lines read as inactive.
// Ports:
//   clk  in  1      destination clock
//   rst  in  1      asynchronous active-high reset
//   d    in  WIDTH  asynchronous input
//   q    out WIDTH  synchronized output (two clocks of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces the
// press and the release of a single key, and reports each accepted press as
// a one-cycle strobe with its hex code.
// Ports:
//   clk_i        in  1  system clock
//   rst_i        in  1  asynchronous active-high reset
//   rows_i       in  4  keypad rows, active-low, asynchronous
//   cols_o       out 4  column drive, active-low, exactly one bit low
//   key_code_o   out 4  code of the last accepted key
//   key_valid_o  out 1  one-cycle strobe when key_code_o updates
//   key_held_o   out 1  high while the accepted key stays pressed
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ    = 100_000_000,
  parameter int SCAN_RATE_HZ     = 1000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] rows_i,
  output logic [3:0] cols_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o
);

  localparam int               DWELL      = CLOCK_FREQ_HZ / SCAN_RATE_HZ;
  localparam int               CNT_W      = $clog2(DWELL);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [3:0]       SAMPLES_N  = 4'(DEBOUNCE_SAMPLES);

  logic [3:0]       rows_sync;
  logic [CNT_W-1:0] dwell_cnt;
  logic             sample;
  logic             any_row_low;
  logic [1:0]       hit_row;

  state_t           state, state_next;
  logic [COL_W-1:0] col, col_next;
  logic [1:0]       row_lat, row_lat_next;
  logic [3:0]       match_cnt, match_cnt_next;
  logic [3:0]       release_cnt, release_cnt_next;
  logic [3:0]       key_code_next;
  logic             key_valid_next;

  sync_2ff #(
    .WIDTH(4)
  ) u_row_sync (
    .clk(clk_i),
    .rst(rst_i),
    .d  (rows_i),
    .q  (rows_sync)
  );

  // Sampling on the last dwell cycle leaves DWELL-1 cycles for the rows
  // to settle after each column change.
  assign sample = (dwell_cnt == DWELL_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dwell_cnt <= '0;
    end else if (sample) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  // Lowest-index low row wins when several rows share the active column.
  assign any_row_low = ~&rows_sync;

  always_comb begin
    hit_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_sync[r]) begin
        hit_row = 2'(r);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= SCAN;
      col         <= '0;
      row_lat     <= '0;
      match_cnt   <= '0;
      release_cnt <= '0;
      key_code_o  <= '0;
      key_valid_o <= 1'b0;
    end else begin
      state       <= state_next;
      col         <= col_next;
      row_lat     <= row_lat_next;
      match_cnt   <= match_cnt_next;
      release_cnt <= release_cnt_next;
      key_code_o  <= key_code_next;
      key_valid_o <= key_valid_next;
    end
  end

  // The column only advances on a sample, so the column change always
  // coincides with the dwell counter wrapping to zero.
  always_comb begin
    state_next       = state;
    col_next         = col;
    row_lat_next     = row_lat;
    match_cnt_next   = match_cnt;
    release_cnt_next = release_cnt;
    key_code_next    = key_code_o;
    key_valid_next   = 1'b0;

    case (state)
      SCAN: begin
        if (sample) begin
          if (any_row_low) begin
            row_lat_next   = hit_row;
            match_cnt_next = '0;
            state_next     = DEBOUNCE;
          end else begin
            col_next = col + COL_W'(1);
          end
        end
      end

      DEBOUNCE: begin
        if (sample) begin
          if (!rows_sync[row_lat]) begin
            match_cnt_next = match_cnt + 4'd1;
            if (match_cnt + 4'd1 == SAMPLES_N) begin
              key_code_next    = key_lookup(row_lat, col);
              key_valid_next   = 1'b1;
              release_cnt_next = '0;
              state_next       = HELD;
            end
          end else begin
            state_next = SCAN;
            col_next   = col + COL_W'(1);
          end
        end
      end

      HELD: begin
        if (sample) begin
          if (rows_sync[row_lat]) begin
            release_cnt_next = release_cnt + 4'd1;
            if (release_cnt + 4'd1 == SAMPLES_N) begin
              state_next = SCAN;
              col_next   = col + COL_W'(1);
            end
          end else begin
            release_cnt_next = '0;
          end
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

  assign cols_o     = ~(NUM_COLS'(1) << col);
  assign key_held_o = (state == HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with DWELL=10 and three debounce
// samples. A keypad model pulls a row low whenever a pressed key's column is
// driven. Cycle k is the k-th rising edge after reset release; columns are
// active for cycles 10c..10c+9, and a decision made at edge 10m sees the
// raw rows of cycle 10m-3 through the synchronizer.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;
  int cycle;

  int         pulse_count;
  int         double_pulses = 0;
  int         stray_code_changes = 0;
  logic [3:0] last_code;
  logic       prev_valid;
  logic [3:0] prev_code;

  always #5 clk = ~clk;

  keypad_scanner #(
    .CLOCK_FREQ_HZ   (1000),
    .SCAN_RATE_HZ    (100),
    .DEBOUNCE_SAMPLES(3)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rows_i     (rows),
    .cols_o     (cols),
    .key_code_o (key_code),
    .key_valid_o(key_valid),
    .key_held_o (key_held)
  );

  // Key {r,c} is bit r*4+c of pressed.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols[c]) begin
          rows[r] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cycle <= 0;
    else     cycle <= cycle + 1;
  end

  // Strobe monitor, sampled 3 time units after each rising edge.
  always @(posedge clk) begin
    #3;
    if (rst) begin
      pulse_count = 0;
      prev_valid  = 1'b0;
      prev_code   = key_code;
      last_code   = key_code;
    end else begin
      if (key_valid) begin
        pulse_count++;
        last_code = key_code;
        if (prev_valid) double_pulses++;
      end else if (key_code !== prev_code) begin
        stray_code_changes++;
      end
      prev_valid = key_valid;
      prev_code  = key_code;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic runTo(input int target);
    int guard;
    guard = 0;
    while (cycle < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cycle != target) checkOutput("run_timeout", 32'(cycle), 32'(target));
  endtask

  task automatic applyReset(input logic [15:0] mask);
    @(negedge clk);
    rst     = 1'b1;
    pressed = mask;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int at_cycle, input logic [15:0] mask);
    runTo(at_cycle);
    pressed = mask;
  endtask

  int         rot_cycle [7] = '{9, 10, 19, 20, 30, 39, 40};
  logic [3:0] rot_cols  [7] = '{4'hE, 4'hD, 4'hD, 4'hB, 4'h7, 4'h7, 4'hE};

  initial begin
    rst     = 1'b1;
    pressed = '0;

    // Reset values and free-running rotation
    applyReset(16'h0000);
    checkOutput("reset_cols", 32'(cols), 'hE);
    checkOutput("reset_code", 32'(key_code), 'h0);
    checkOutput("reset_valid", 32'(key_valid), 'h0);
    checkOutput("reset_held", 32'(key_held), 'h0);
    for (int i = 0; i < 7; i++) begin
      runTo(rot_cycle[i]);
      checkOutput($sformatf("rotate_c%0d", rot_cycle[i]), 32'(cols), 32'(rot_cols[i]));
    end

    // Clean press of r1c2: detected at edge 30, strobe at cycle 60
    applyReset(16'h0040);
    runTo(59);
    checkOutput("clean_no_early", 32'(pulse_count), 'd0);
    checkOutput("clean_frozen_col", 32'(cols), 'hB);
    runTo(60);
    checkOutput("clean_valid", 32'(key_valid), 'h1);
    checkOutput("clean_code", 32'(key_code), 'h6);
    checkOutput("clean_held", 32'(key_held), 'h1);
    runTo(61);
    checkOutput("clean_valid_drop", 32'(key_valid), 'h0);
    applyStimulus(200, 16'h0000);
    runTo(229);
    checkOutput("clean_held_late", 32'(key_held), 'h1);
    runTo(230);
    checkOutput("clean_released", 32'(key_held), 'h0);
    checkOutput("clean_next_col", 32'(cols), 'h7);
    runTo(260);
    checkOutput("clean_one_pulse", 32'(pulse_count), 'd1);
    checkOutput("clean_code_hold", 32'(key_code), 'h6);

    // Bouncing r3c0: aborted debounce, then one strobe on the next visit
    applyReset(16'h0000);
    for (int t = 0; t < 40; t++) begin
      applyStimulus(t, ((t / 7) % 2 == 1) ? 16'h1000 : 16'h0000);
      if (t == 15) checkOutput("bounce_frozen", 32'(cols), 'hE);
      if (t == 20) checkOutput("bounce_abort_col", 32'(cols), 'hD);
    end
    applyStimulus(40, 16'h1000);
    runTo(89);
    checkOutput("bounce_no_strobe", 32'(pulse_count), 'd0);
    runTo(90);
    checkOutput("bounce_valid", 32'(key_valid), 'h1);
    checkOutput("bounce_code", 32'(last_code), 'h0);
    runTo(100);
    checkOutput("bounce_one_pulse", 32'(pulse_count), 'd1);

    // r0c3 and r2c3 together, then r0c0 added while held
    applyReset(16'h0808);
    runTo(70);
    checkOutput("multi_valid", 32'(key_valid), 'h1);
    checkOutput("multi_code", 32'(key_code), 'hA);
    applyStimulus(80, 16'h0809);
    runTo(149);
    checkOutput("multi_no_rollover", 32'(pulse_count), 'd1);
    checkOutput("multi_held", 32'(key_held), 'h1);
    applyStimulus(150, 16'h0001);
    runTo(179);
    checkOutput("multi_held_late", 32'(key_held), 'h1);
    runTo(180);
    checkOutput("multi_released", 32'(key_held), 'h0);
    checkOutput("multi_col0", 32'(cols), 'hE);
    runTo(219);
    checkOutput("multi_second_wait", 32'(pulse_count), 'd1);
    runTo(220);
    checkOutput("multi_second_valid", 32'(key_valid), 'h1);
    checkOutput("multi_second_code", 32'(key_code), 'h1);

    // 15-cycle glitch on r2c2
    applyReset(16'h0000);
    applyStimulus(20, 16'h0400);
    applyStimulus(35, 16'h0000);
    checkOutput("glitch_frozen", 32'(cols), 'hB);
    checkOutput("glitch_not_held", 32'(key_held), 'h0);
    runTo(40);
    checkOutput("glitch_next_col", 32'(cols), 'h7);
    runTo(100);
    checkOutput("glitch_no_strobe", 32'(pulse_count), 'd0);

    // Reset while r2c1 is held
    applyReset(16'h0200);
    runTo(50);
    checkOutput("midrst_first_code", 32'(key_code), 'h8);
    checkOutput("midrst_first_held", 32'(key_held), 'h1);
    runTo(60);
    rst = 1'b1;
    #1;
    checkOutput("midrst_cols", 32'(cols), 'hE);
    checkOutput("midrst_code", 32'(key_code), 'h0);
    checkOutput("midrst_held", 32'(key_held), 'h0);
    checkOutput("midrst_valid", 32'(key_valid), 'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    runTo(49);
    checkOutput("midrst_no_early", 32'(pulse_count), 'd0);
    runTo(50);
    checkOutput("midrst_valid_again", 32'(key_valid), 'h1);
    checkOutput("midrst_code_again", 32'(key_code), 'h8);

    runTo(60);
    checkOutput("double_pulse", 32'(double_pulses), 'd0);
    checkOutput("stray_code", 32'(stray_code_changes), 'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
